// File: rtl/led_fade_pwm_pkg.sv
// Purpose: shared widths and reset constants for the LED fade/PWM block.
// Latency: n/a (declarations only).
// Backpressure: none; constants only.
package led_fade_pwm_pkg;

  localparam int LEVEL_W = 8;
  localparam int PWM_W   = 8;

  localparam logic [LEVEL_W-1:0] LEVEL_RST = 8'h00;
  localparam logic [PWM_W-1:0]   PWM_OFF   = 8'h00;

endpackage

// File: rtl/led_fade_channel.sv
// Purpose: one LED channel; ramps a brightness level toward on/off and compares it with the shared PWM count.
// Latency: level moves one STEP per tick; pwm_out is registered 1 cycle after level/pwm_cnt; busy is combinational.
// Backpressure: none; the on bit is level-sampled and the channel always follows it.
module led_fade_channel
  import led_fade_pwm_pkg::*;
#(
  parameter int STEP      = 8,
  parameter int MAX_LEVEL = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             tick,
  input  logic             on,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             pwm_out,
  output logic             busy
);

  localparam int LW1 = LEVEL_W + 1;
  localparam logic [LEVEL_W:0]   STEP_X = LW1'(STEP);
  localparam logic [LEVEL_W-1:0] MAX_L  = LEVEL_W'(MAX_LEVEL);

  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W-1:0] target;
  logic [LEVEL_W-1:0] level_nxt;
  logic [LEVEL_W:0]   up_sum;
  logic [LEVEL_W:0]   dn_floor;

  // Saturating step toward the target; sums carry a 9th bit so nothing wraps.
  always_comb begin
    target    = on ? MAX_L : LEVEL_RST;
    up_sum    = {1'b0, level} + STEP_X;
    dn_floor  = {1'b0, target} + STEP_X;
    level_nxt = level;
    if (level < target) begin
      level_nxt = (up_sum > {1'b0, target}) ? target : up_sum[LEVEL_W-1:0];
    end else if (level > target) begin
      level_nxt = ({1'b0, level} > dn_floor) ? (level - STEP_X[LEVEL_W-1:0]) : target;
    end
  end

  // Top level registers the OR of all channels, so this stays combinational.
  assign busy = (level != target);

  // Level advances only on ticks; full level forces a constant-on output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level   <= LEVEL_RST;
      pwm_out <= 1'b0;
    end else begin
      if (tick) begin
        level <= level_nxt;
      end
      pwm_out <= (level == '1) || (pwm_cnt < level);
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Purpose: turns the LED peripheral's 8-bit register into faded, PWM-dimmed LED drives.
// Latency: LED_IN -> led_q 1 cycle; ramp of ceil(MAX_LEVEL/STEP) ticks; LED_PWM/FADE_BUSY 1 cycle after level.
// Backpressure: none; LED_IN is level-sampled every cycle with no handshake.
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int FADE_DIV  = 1000,
  parameter int STEP      = 8,
  parameter int MAX_LEVEL = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] LED_IN,
  output logic [7:0] LED_PWM,
  output logic       FADE_BUSY
);

  localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FADE_DIV - 1);

  logic [7:0]       led_q;
  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [PWM_W-1:0] pwm_cnt;
  logic [7:0]       ch_pwm;
  logic [7:0]       ch_busy;

  // With FADE_DIV=1 the prescaler sits at 0 and every cycle is a tick.
  assign tick = (presc == PRE_LAST);

  // Input register, fade prescaler, shared free-running PWM counter and busy flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q     <= 8'h00;
      presc     <= '0;
      pwm_cnt   <= PWM_OFF;
      FADE_BUSY <= 1'b0;
    end else begin
      led_q     <= LED_IN;
      presc     <= tick ? '0 : presc + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
      FADE_BUSY <= |ch_busy;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_ch
    led_fade_channel #(
      .STEP      (STEP),
      .MAX_LEVEL (MAX_LEVEL)
    ) u_ch (
      .CLK     (CLK),
      .RESET   (RESET),
      .tick    (tick),
      .on      (led_q[i]),
      .pwm_cnt (pwm_cnt),
      .pwm_out (ch_pwm[i]),
      .busy    (ch_busy[i])
    );
  end

  // Channel outputs are already registered.
  assign LED_PWM = ch_pwm;

endmodule
